// File: rtl/spike_out_aer_packer_if.sv
// AER packet stream between the spike output packer and its consumer.
// Ports: o_aer_valid/o_aer_data from packer, i_aer_ready from consumer.
interface spike_out_aer_packer_if #(
    parameter int PKT_WIDTH = 31
) ();
    logic                 o_aer_valid;
    logic                 i_aer_ready;
    logic [PKT_WIDTH-1:0] o_aer_data;

    modport master (
        output o_aer_valid,
        output o_aer_data,
        input  i_aer_ready
    );

    modport slave (
        input  o_aer_valid,
        input  o_aer_data,
        output i_aer_ready
    );
endinterface

// File: rtl/spike_out_aer_packer.sv
// Timestamps SNN core output spikes, buffers them with per-step markers
// in a FWFT FIFO and streams them out as AER packets.
// Ports: clk, rst (sync, active-high); i_spike_valid/i_spike_addr and
// i_step_done from the core; aer (master) packet stream; o_timestep,
// o_overflow (sticky, cleared by i_clear_overflow), o_fifo_level.
module spike_out_aer_packer #(
    parameter int ADDR_WIDTH = 14,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 64,
    localparam int PKT_WIDTH = 1 + TS_WIDTH + ADDR_WIDTH,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_spike_valid,
    input  logic [ADDR_WIDTH-1:0] i_spike_addr,
    input  logic                  i_step_done,
    spike_out_aer_packer_if.master aer,
    output logic [TS_WIDTH-1:0]   o_timestep,
    output logic                  o_overflow,
    input  logic                  i_clear_overflow,
    output logic [LVL_W-1:0]      o_fifo_level
);

    logic [PKT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      marker_ptr;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [LVL_W-1:0]      free;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] cnt_step;
    logic                  ovf_q, ovf_d;
    logic                  spike_acc, marker_acc;
    logic                  drop, pop, not_empty;
    logic [PKT_WIDTH-1:0]  spike_pkt, marker_pkt;

    always_comb begin
        // Credit is taken from the start-of-cycle level only; a pop in
        // this cycle does not free space for this cycle's writes.
        free      = LVL_W'(FIFO_DEPTH) - level_q;
        not_empty = (level_q != '0);
        pop       = not_empty && aer.i_aer_ready;

        // One slot is always held back so the step marker survives a
        // spike flood.
        spike_acc  = i_spike_valid && (free >= LVL_W'(2));
        marker_acc = i_step_done &&
                     (spike_acc ? (free >= LVL_W'(2))
                                : (free >= LVL_W'(1)));
        drop = (i_spike_valid && !spike_acc) ||
               (i_step_done && !marker_acc);

        // Saturating count; includes a spike coincident with step_done.
        cnt_step = cnt_q;
        if (i_spike_valid && (cnt_q != '1)) begin
            cnt_step = cnt_q + 1'b1;
        end

        spike_pkt  = {1'b0, ts_q, i_spike_addr};
        marker_pkt = {1'b1, ts_q, cnt_step};
        // Marker lands behind a same-cycle spike.
        marker_ptr = wr_ptr_q + PTR_W'(spike_acc);

        wr_ptr_d = wr_ptr_q + PTR_W'(spike_acc) + PTR_W'(marker_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(spike_acc) + LVL_W'(marker_acc)
                 - LVL_W'(pop);

        ts_d  = i_step_done ? ts_q + 1'b1 : ts_q;
        cnt_d = i_step_done ? '0 : cnt_step;

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clear_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ts_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ts_q     <= ts_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: contents are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (spike_acc) begin
                mem_q[wr_ptr_q] <= spike_pkt;
            end
            if (marker_acc) begin
                mem_q[marker_ptr] <= marker_pkt;
            end
        end
    end

    assign aer.o_aer_valid = not_empty;
    assign aer.o_aer_data  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign o_timestep      = ts_q;
    assign o_overflow      = ovf_q;
    assign o_fifo_level    = level_q;

endmodule

// File: doc/spike_out_aer_packer.md
Name: spike_out_aer_packer

Overview:
Output stage directly downstream of the SNN core's output spike event interface (spike valid/addr, per-timestep done pulse). The core cannot be stalled. This block timestamps each output spike, buffers it in a FIFO, and emits Address-Event Representation (AER) packets over a valid/ready stream. Each timestep is closed with an end-of-timestep marker packet carrying that step's spike count.

Parameters:
ADDR_WIDTH, 14, neuron address width; also the width of the marker count field
TS_WIDTH, 16, timestep counter width
FIFO_DEPTH, 64, packet FIFO entries; power of two, >= 4
PKT_WIDTH, 1+TS_WIDTH+ADDR_WIDTH, packet width; derived, not overridden

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous, active-high
i_spike_valid  in  1  output spike from core, one per cycle max
i_spike_addr  in  ADDR_WIDTH  address of the spiking neuron
i_step_done  in  1  single-cycle pulse; closes the current timestep
o_aer_valid  out  1  packet available on o_aer_data
i_aer_ready  in  1  consumer accepts the packet
o_aer_data  out  PKT_WIDTH  packet {type[1], ts[TS_WIDTH], payload[ADDR_WIDTH]}
o_timestep  out  TS_WIDTH  current timestep number
o_overflow  out  1  sticky: at least one packet was dropped
i_clear_overflow  in  1  clears o_overflow
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (synchronous, active-high) clears the FIFO, timestep, step count and overflow flag. All outputs read 0 on the cycle after rst is sampled high. A reset mid-stream discards buffered packets with no partial output.
- Packet formats:
  - Spike packet: type=0, ts=o_timestep at arrival, payload=i_spike_addr.
  - Marker packet: type=1, ts=timestep being closed, payload=step spike count.
- Step count:
  - Counts every i_spike_valid cycle in the step, dropped spikes included.
  - Saturates at 2^ADDR_WIDTH-1.
  - Resets to 0 after the marker is generated.
- A spike in the same cycle as i_step_done belongs to the closing step:
  - It is counted in that step's marker.
  - It is written to the FIFO before the marker.
- i_step_done increments o_timestep on the next edge. Wraps from 2^TS_WIDTH-1 to 0.
- FIFO write port:
  - Up to two writes per cycle, in order: spike, then marker.
  - free = FIFO_DEPTH - level. Level is the start-of-cycle value; a pop in the same cycle gives no credit.
  - A spike is accepted only if free >= 2. One entry is always reserved for a marker. Otherwise the spike is dropped and o_overflow is set.
  - A marker is accepted if free >= 1, or free >= 2 when a spike is also accepted that cycle. Otherwise the marker is dropped and o_overflow is set.
- FIFO read side:
  - First-word-fall-through from registers.
  - o_aer_valid = (level != 0). o_aer_data = head entry, or all-zero when empty.
  - Pop occurs when o_aer_valid && i_aer_ready.
  - o_aer_data and o_aer_valid are held stable while valid && !ready.
- Latency: a packet written into an empty FIFO at edge N is valid during the cycle after edge N (one cycle).
- Simultaneous push and pop: level changes by (pushes - 1). Pointers wrap modulo FIFO_DEPTH.
- o_overflow: set by any drop; cleared by i_clear_overflow. Set wins if both occur in the same cycle.
- i_aer_ready has no effect when the FIFO is empty.

Test Plan:
- Reset then idle: o_aer_valid=0, o_aer_data=0, o_timestep=0, o_fifo_level=0, o_overflow=0.
- Spikes at addr 5, 9, then i_step_done, with ready=1 → packets {0,0,5}, {0,0,9}, {1,0,2}; o_timestep=1. A further spike addr 3 → {0,1,3}.
- i_step_done together with spike addr 7 at ts=4 → {0,4,7} immediately followed by {1,4,count incl. 7}; level +2 in that cycle.
- FIFO_DEPTH=8, ready=0, 10 consecutive spikes → 7 accepted, 3 dropped, o_overflow=1. Then i_step_done → marker accepted, level=8, marker count=10. Release ready → 8 packets in order, marker last. i_clear_overflow → o_overflow=0.
- Backpressure: ready toggled 1/0 every cycle during a 20-spike burst → no packet lost, duplicated or reordered; data stable while valid && !ready.
- TS_WIDTH=4: 16 step_done pulses → o_timestep wraps 15→0; marker ts=15 precedes the next spike with ts=0. Assert rst mid-burst → FIFO empty and o_timestep=0 next cycle.
